link_egress_queue: RTL

- Per-direction egress buffer between a router output port (N/E/W/S/self) and the neighbouring tile's mailbox FIFO.
- Decouples router arbitration from link back-pressure with a DEPTH-entry circular buffer.
- Drives the neighbour write strobe only when the neighbour is ready; the neighbour's FIFO writes on valid regardless of its full state.
- Reports occupancy and a sticky link-stall flag for debug/watchdog.

---
 rtl/link_egress_queue.sv | 97 +++++++++
 1 files changed

// File: rtl/link_egress_queue.sv
// link_egress_queue: per-direction egress FIFO between a router output port and a neighbour mailbox.
// Latency: 1 cycle push-to-strobe; 0 cycles when idle if LINK_EGRESS_BYPASS_EN is defined.
// Backpressure: the strobe is issued only while out_ready_in is high; in_ready_out drops when full.
module link_egress_queue #(
  parameter int MSG_WIDTH       = 64,
  parameter int DEPTH           = 4,
  parameter int STALL_LIMIT     = 1024,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [MSG_WIDTH-1:0]         in_value_in,
  input  logic                         in_valid_in,
  output logic                         in_ready_out,
  output logic [MSG_WIDTH-1:0]         out_value_out,
  output logic                         out_valid_out,
  input  logic                         out_ready_in,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_out,
  output logic                         stall_flag_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [STALL_CNT_WIDTH-1:0] LIMIT = STALL_CNT_WIDTH'(STALL_LIMIT);

  logic [MSG_WIDTH-1:0]       mem [DEPTH];
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [CW-1:0]              count;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_next;
  logic                       stall_flag;
  logic                       not_empty;
  logic                       bypass;
  logic                       push;
  logic                       pop;
  logic                       blocked;

  assign not_empty = (count != '0);

  // Ready comes from the registered count only, so a same-cycle pop never opens a slot.
  assign in_ready_out = !reset && (count < CW'(DEPTH));

`ifdef LINK_EGRESS_BYPASS_EN
  // Idle queue with a ready neighbour: hand the message straight through without storing it.
  assign bypass = !reset && !not_empty && in_valid_in && out_ready_in;
`else
  assign bypass = 1'b0;
`endif

  assign pop            = !reset && not_empty && out_ready_in;
  assign push           = in_valid_in && in_ready_out && !bypass;
  assign out_valid_out  = pop || bypass;
  assign out_value_out  = bypass ? in_value_in : mem[rd_ptr];
  assign occupancy_out  = count;
  assign stall_flag_out = stall_flag;

  // Head is blocked whenever something is held but the neighbour is not ready.
  assign blocked = not_empty && !out_ready_in;

  // Next stall count: saturating increment while blocked, otherwise restart from zero.
  always_comb begin
    stall_cnt_next = '0;
    if (blocked) begin
      stall_cnt_next = (stall_cnt >= LIMIT) ? LIMIT : stall_cnt + 1'b1;
    end
  end

  // Message storage; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_value_in;
    end
  end

  // Pointers, occupancy and stall watchdog; the flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      stall_cnt  <= '0;
      stall_flag <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count      <= count + CW'(push) - CW'(pop);
      stall_cnt  <= stall_cnt_next;
      stall_flag <= stall_flag | (stall_cnt_next >= LIMIT);
    end
  end

endmodule
